// File: rtl/rf_scoreboard.sv
// Register-file hazard scoreboard: per-register pending-write counters that stall decode
// on RAW hazards and sequence a pipeline drain so halt completes after all writes retire.
module rf_scoreboard #(
   parameter int unsigned CNT_W = 3,
   parameter int unsigned NREG  = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            iss_valid,
   input  logic [3:0]      iss_srcA,
   input  logic [3:0]      iss_srcB,
   input  logic [3:0]      iss_dstE,
   input  logic [3:0]      iss_dstM,
   output logic            stall,
   input  logic            wbE_valid,
   input  logic [3:0]      wbE_reg,
   input  logic            wbM_valid,
   input  logic [3:0]      wbM_reg,
   input  logic            sq_valid,
   input  logic [3:0]      sq_dstE,
   input  logic [3:0]      sq_dstM,
   input  logic            drain_req,
   output logic            drain_done,
   output logic [NREG-1:0] busy_mask,
   output logic [3:0]      inflight,
   output logic            err_underflow
);
   localparam int unsigned SUM_W   = CNT_W + 2;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt      [NREG];
   logic [CNT_W-1:0] w_cnt_nxt  [NREG];
   logic [1:0]       w_inc      [NREG];
   logic [2:0]       w_dec      [NREG];
   logic [SUM_W-1:0] w_sum      [NREG];
   logic [NREG-1:0]  w_busy_nxt;
   logic [NREG-1:0]  r_busy_mask;
   logic [3:0]       w_inflight_nxt;
   logic [3:0]       r_inflight;
   logic             w_haz;
   logic             w_ovf;
   logic             w_accept;
   logic             w_uflow;
   logic             w_all_zero;
   logic             r_drain_done;
   logic             r_err_underflow;

   // Hazard and overflow look only at registered counters, so wb/sq never reach stall.
   always_comb begin
      w_haz = 1'b0;
      w_ovf = 1'b0;
      for (int r = 0; r < int'(NREG); r++) begin
         w_inc[r] = 2'(iss_dstE == 4'(r)) + 2'(iss_dstM == 4'(r));
         if ((iss_srcA == 4'(r) || iss_srcB == 4'(r)) && r_cnt[r] != '0)
            w_haz = 1'b1;
         if (SUM_W'(r_cnt[r]) + SUM_W'(w_inc[r]) > SUM_W'(CNT_MAX))
            w_ovf = 1'b1;
      end
   end

   assign stall    = iss_valid & (w_haz | w_ovf | (r_state != ST_RUN));
   assign w_accept = iss_valid & ~stall;

   // Next counter = cnt + inc - dec, clamped at zero with an underflow flag.
   always_comb begin
      w_uflow        = 1'b0;
      w_busy_nxt     = '0;
      w_inflight_nxt = '0;
      for (int r = 0; r < int'(NREG); r++) begin
         w_dec[r] = 3'(wbE_valid && wbE_reg == 4'(r)) + 3'(wbM_valid && wbM_reg == 4'(r))
                  + 3'(sq_valid && sq_dstE == 4'(r)) + 3'(sq_valid && sq_dstM == 4'(r));
         w_sum[r] = SUM_W'(r_cnt[r]) + (w_accept ? SUM_W'(w_inc[r]) : SUM_W'(0));
         if (SUM_W'(w_dec[r]) > w_sum[r]) begin
            w_cnt_nxt[r] = '0;
            w_uflow      = 1'b1;
         end else begin
            w_cnt_nxt[r] = CNT_W'(w_sum[r] - SUM_W'(w_dec[r]));
         end
         w_busy_nxt[r]  = (w_cnt_nxt[r] != '0);
         w_inflight_nxt = w_inflight_nxt + 4'(w_busy_nxt[r]);
      end
      w_all_zero = (w_busy_nxt == '0);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:   if (drain_req) w_state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (!drain_req)     w_state_nxt = ST_RUN;
            else if (w_all_zero) w_state_nxt = ST_DONE;
         end
         ST_DONE:  if (!drain_req) w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < int'(NREG); r++) r_cnt[r] <= '0;
         r_busy_mask     <= '0;
         r_inflight      <= '0;
         r_drain_done    <= 1'b0;
         r_err_underflow <= 1'b0;
      end else begin
         for (int r = 0; r < int'(NREG); r++) r_cnt[r] <= w_cnt_nxt[r];
         r_busy_mask     <= w_busy_nxt;
         r_inflight      <= w_inflight_nxt;
         r_drain_done    <= (w_state_nxt == ST_DONE);
         r_err_underflow <= r_err_underflow | w_uflow;
      end
   end

   assign busy_mask     = r_busy_mask;
   assign inflight      = r_inflight;
   assign drain_done    = r_drain_done;
   assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: RAW stalls, popq double-write, same-cycle issue/retire,
// squash underflow, drain sequencing, overflow stall and asynchronous reset.
module tb_rf_scoreboard;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        iss_valid;
   logic [3:0]  iss_srcA, iss_srcB, iss_dstE, iss_dstM;
   logic        stall;
   logic        wbE_valid, wbM_valid, sq_valid;
   logic [3:0]  wbE_reg, wbM_reg, sq_dstE, sq_dstM;
   logic        drain_req, drain_done;
   logic [14:0] busy_mask;
   logic [3:0]  inflight;
   logic        err_underflow;

   int errors = 0;
   int checks = 0;

   rf_scoreboard dut (
      .clk(clk), .rst_n(rst_n),
      .iss_valid(iss_valid), .iss_srcA(iss_srcA), .iss_srcB(iss_srcB),
      .iss_dstE(iss_dstE), .iss_dstM(iss_dstM), .stall(stall),
      .wbE_valid(wbE_valid), .wbE_reg(wbE_reg), .wbM_valid(wbM_valid), .wbM_reg(wbM_reg),
      .sq_valid(sq_valid), .sq_dstE(sq_dstE), .sq_dstM(sq_dstM),
      .drain_req(drain_req), .drain_done(drain_done),
      .busy_mask(busy_mask), .inflight(inflight), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   task automatic idle();
      iss_valid = 1'b0; iss_srcA = 4'hF; iss_srcB = 4'hF; iss_dstE = 4'hF; iss_dstM = 4'hF;
      wbE_valid = 1'b0; wbE_reg = 4'hF; wbM_valid = 1'b0; wbM_reg = 4'hF;
      sq_valid = 1'b0; sq_dstE = 4'hF; sq_dstM = 4'hF;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] e, input logic [3:0] m);
      iss_valid = 1'b1; iss_srcA = a; iss_srcB = b; iss_dstE = e; iss_dstM = m;
   endtask

   task automatic test_reset();
      idle(); drain_req = 1'b0; rst_n = 1'b0;
      #12;
      checks++; if (busy_mask !== 15'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy_mask); end
      checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
      checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL reset_drain_done: got %b want 0", drain_done); end
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_underflow); end
      rst_n = 1'b1;
      issue(4'd0, 4'hF, 4'd0, 4'hF); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
      idle();
   endtask

   task automatic test_raw();
      issue(4'hF, 4'hF, 4'd0, 4'hF); step(); idle();
      checks++; if (busy_mask !== 15'h0001) begin errors++; $display("FAIL raw_busy: got %h want 0001", busy_mask); end
      checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL raw_inflight: got %0d want 1", inflight); end
      issue(4'd0, 4'd1, 4'd1, 4'hF); wbE_valid = 1'b1; wbE_reg = 4'd0; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b want 1", stall); end
      step(); wbE_valid = 1'b0; #1;
      checks++; if (busy_mask !== 15'h0) begin errors++; $display("FAIL raw_busy_clr: got %h want 0", busy_mask); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_stall_clr: got %b want 0", stall); end
      idle();
   endtask

   task automatic test_popq();
      issue(4'd4, 4'd4, 4'd4, 4'd4); step(); idle();
      checks++; if (busy_mask !== 15'h0010) begin errors++; $display("FAIL popq_busy: got %h want 0010", busy_mask); end
      wbE_valid = 1'b1; wbE_reg = 4'd4; step(); idle();
      checks++; if (busy_mask !== 15'h0010) begin errors++; $display("FAIL popq_half: got %h want 0010", busy_mask); end
      issue(4'd4, 4'hF, 4'hF, 4'hF); #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL popq_stall: got %b want 1", stall); end
      idle(); wbM_valid = 1'b1; wbM_reg = 4'd4; step(); idle();
      checks++; if (busy_mask !== 15'h0) begin errors++; $display("FAIL popq_clr: got %h want 0", busy_mask); end
   endtask

   task automatic test_back_to_back();
      issue(4'hF, 4'hF, 4'd3, 4'hF); step(); idle();
      issue(4'hF, 4'hF, 4'd3, 4'hF); wbE_valid = 1'b1; wbE_reg = 4'd3; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b want 0", stall); end
      step(); idle();
      checks++; if (busy_mask !== 15'h0008) begin errors++; $display("FAIL b2b_busy: got %h want 0008", busy_mask); end
      checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL b2b_inflight: got %0d want 1", inflight); end
      wbE_valid = 1'b1; wbE_reg = 4'd3; step(); idle();
      checks++; if (busy_mask !== 15'h0) begin errors++; $display("FAIL b2b_clr: got %h want 0", busy_mask); end
   endtask

   task automatic test_squash();
      issue(4'hF, 4'hF, 4'd2, 4'hF); step(); idle();
      checks++; if (busy_mask !== 15'h0004) begin errors++; $display("FAIL sq_busy: got %h want 0004", busy_mask); end
      sq_valid = 1'b1; sq_dstE = 4'd2; step(); idle();
      checks++; if (busy_mask !== 15'h0) begin errors++; $display("FAIL sq_clr: got %h want 0", busy_mask); end
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL sq_noerr: got %b want 0", err_underflow); end
      wbE_valid = 1'b1; wbE_reg = 4'd2; step(); idle();
      checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL sq_uflow: got %b want 1", err_underflow); end
      checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL sq_inflight: got %0d want 0", inflight); end
      step();
      checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL sq_sticky: got %b want 1", err_underflow); end
   endtask

   task automatic test_drain();
      issue(4'hF, 4'hF, 4'd1, 4'd5); step(); idle();
      checks++; if (busy_mask !== 15'h0022) begin errors++; $display("FAIL drn_busy: got %h want 0022", busy_mask); end
      checks++; if (inflight !== 4'd2) begin errors++; $display("FAIL drn_inflight: got %0d want 2", inflight); end
      drain_req = 1'b1; step();
      issue(4'hF, 4'hF, 4'd7, 4'hF); #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL drn_stall: got %b want 1", stall); end
      checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL drn_early: got %b want 0", drain_done); end
      idle(); wbE_valid = 1'b1; wbE_reg = 4'd1; wbM_valid = 1'b1; wbM_reg = 4'd5; step(); idle();
      checks++; if (drain_done !== 1'b1) begin errors++; $display("FAIL drn_done: got %b want 1", drain_done); end
      checks++; if (busy_mask !== 15'h0) begin errors++; $display("FAIL drn_busy_clr: got %h want 0", busy_mask); end
      step();
      checks++; if (drain_done !== 1'b1) begin errors++; $display("FAIL drn_hold: got %b want 1", drain_done); end
      drain_req = 1'b0; step();
      issue(4'hF, 4'hF, 4'hF, 4'hF); #1;
      checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL drn_release: got %b want 0", drain_done); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL drn_run_stall: got %b want 0", stall); end
      idle();
      // Drain abandoned while a write is still pending.
      issue(4'hF, 4'hF, 4'd9, 4'hF); step(); idle();
      drain_req = 1'b1; step(); drain_req = 1'b0; step();
      issue(4'hF, 4'hF, 4'hF, 4'hF); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL drn_cancel: got %b want 0", stall); end
      checks++; if (busy_mask !== 15'h0200) begin errors++; $display("FAIL drn_cancel_busy: got %h want 0200", busy_mask); end
      idle(); wbE_valid = 1'b1; wbE_reg = 4'd9; step(); idle();
   endtask

   task automatic test_ovf_reset();
      for (int i = 0; i < 7; i++) begin
         issue(4'hF, 4'hF, 4'd6, 4'hF); step();
      end
      checks++; if (busy_mask !== 15'h0040) begin errors++; $display("FAIL ovf_busy: got %h want 0040", busy_mask); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ovf_stall: got %b want 1", stall); end
      checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL ovf_err_pre: got %b want 1", err_underflow); end
      #2 rst_n = 1'b0; #1;
      checks++; if (busy_mask !== 15'h0) begin errors++; $display("FAIL rst_busy: got %h want 0", busy_mask); end
      checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL rst_inflight: got %0d want 0", inflight); end
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_underflow); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
      rst_n = 1'b1; idle();
      wbE_valid = 1'b1; wbE_reg = 4'd6; step(); idle();
      checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL rst_late_wb: got %b want 1", err_underflow); end
   endtask

   initial begin
      test_reset();
      test_raw();
      test_popq();
      test_back_to_back();
      test_squash();
      test_drain();
      test_ovf_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Register-file hazard scoreboard for the 5-stage Y86-64 pipeline. It sits beside the decode-stage register file. It tracks in-flight writes to the 15 program registers (%rax..%r14) and stalls decode on read-after-write hazards. It also sequences a pipeline drain so that halt completes only after every outstanding register write has retired.

## Interface
- `CNT_W`, default 3: width of each per-register pending counter (saturation limit 2^CNT_W−1 = 7).
- `NREG`, default 15: number of tracked registers, IDs 0..14. ID 4'hF means RNONE.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `iss_valid` in 1: decode presents an instruction.
- `iss_srcA` in 4: first source register ID (F = none).
- `iss_srcB` in 4: second source register ID (F = none).
- `iss_dstE` in 4: ALU-result destination ID (F = none).
- `iss_dstM` in 4: memory-result destination ID (F = none).
- `stall` out 1: decode must hold; the instruction is not accepted this cycle.
- `wbE_valid` in 1: writeback of valE retires this cycle.
- `wbE_reg` in 4: register ID written by valE.
- `wbM_valid` in 1: writeback of valM retires this cycle.
- `wbM_reg` in 4: register ID written by valM.
- `sq_valid` in 1: an already-issued instruction is squashed (mispredict or ret bubble).
- `sq_dstE` in 4: squashed instruction's dstE.
- `sq_dstM` in 4: squashed instruction's dstM.
- `drain_req` in 1: level request to drain (halt seen in decode).
- `drain_done` out 1: drain complete.
- `busy_mask` out 15: bit r set iff the counter for r is nonzero.
- `inflight` out 4: number of registers with a nonzero counter.
- `err_underflow` out 1: sticky; a decrement hit a zero counter.

## Operation
- One `CNT_W`-bit counter per register, 0..14. ID F is ignored everywhere.
- Hazard condition `haz`: (srcA≠F and cnt[srcA]≠0) or (srcB≠F and cnt[srcB]≠0). Only registered counters are used; a same-cycle writeback does not clear a hazard.
- Overflow condition `ovf`: an accept would push any destination counter above 7.
- `stall` = iss_valid & (haz | ovf | state≠RUN). It is combinational.
- Accept = iss_valid & !stall.
- Counter next value = cnt + inc − dec.
  - inc: +1 for dstE on accept, +1 for dstM on accept. dstE==dstM (popq %rsp) gives +2.
  - dec: +1 each for wbE, wbM, sq_dstE and sq_dstM (when sq_valid) matching the register. Decrements sum, so up to 4 per cycle.
  - Issue and retire to the same register in one cycle net out in the same update.
- Underflow: if dec > cnt + inc, the counter becomes 0 and err_underflow sets. err_underflow clears only on reset.
- State machine:
  - RUN: normal operation. drain_req=1 moves to DRAIN.
  - DRAIN: no accepts. When all counters are 0 (next-state values), move to DONE.
  - DONE: drain_done=1. drain_req=0 returns to RUN.
  - drain_req dropping while in DRAIN returns to RUN.
- busy_mask and inflight are registered and derived from the next-state counters, so they are coherent with the counters after each edge.

## Timing
- Reset (rst_n=0, asynchronous) sets:
  - all counters 0
  - state RUN
  - busy_mask 0, inflight 0
  - drain_done 0, err_underflow 0
  - stall therefore follows iss_valid & 0, i.e. 0.
- Counters update on the rising clk edge. A consumer of a register issued at edge N stalls from cycle N+1 until the edge after its last writeback.
- A reset asserted mid-drain aborts the drain. The block returns to RUN with an empty scoreboard, and pending writebacks after reset count as underflow.
- drain_done asserts the cycle after the counters reach 0 and stays high while drain_req=1.
- No combinational path exists from the wb or sq inputs to stall.

## Test plan
- Reset, then issue irmovq (dstE=0) → busy_mask=0x0001, inflight=1. Issue addq srcA=0 → stall=1. Pulse wbE_reg=0 → next cycle busy_mask=0, stall=0.
- popq %rsp (dstE=4, dstM=4) accepted → cnt[4]=2. wbE_reg=4 → cnt[4]=1, still busy. wbM_reg=4 → busy_mask bit 4 clears.
- In one cycle: accept dstE=3 while wbE_reg=3 retires an older write with cnt[3]=1 → cnt[3] stays 1 and bit 3 stays set.
- Issue dstE=2, then sq_valid with sq_dstE=2 → cnt[2]=0. A further wbE_reg=2 → err_underflow=1 and cnt[2] stays 0.
- Two writes in flight (regs 1 and 5); raise drain_req → the next iss_valid stalls. Retire both → drain_done=1 one cycle later. Drop drain_req → RUN, stall=0.
- Seven accepts with dstE=6 and no retire → eighth accept stalls (ovf). Assert rst_n=0 mid-sequence → all outputs 0 immediately.
